// File: rtl/count_capture_fifo.sv
// count_capture_fifo: snapshots a free-running counter on each rising edge of an
// asynchronous trigger pin into a small first-word-fall-through FIFO, read out
// through a valid/ack handshake. A dropped capture sets a sticky overflow flag.
module count_capture_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       trig_in,
  input  logic                       clr,
  input  logic                       rd_ack,
  output logic [WIDTH-1:0]           cap_data,
  output logic                       cap_valid,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;
  logic                   cap_pulse;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   full, pop, wr_en, pop_en;

  // Synchronizer chain for the async trigger, plus the edge-detect history flop.
  // Both survive clr so a trigger level held across a flush is not recaptured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cap_pulse = sync_q[SYNC_STAGES-1] & ~s_prev;

  assign full      = (level == FULL_LVL);
  assign cap_valid = (level != '0);
  assign pop       = rd_ack & cap_valid;
  // A pop frees the slot the same edge, so a full FIFO still accepts the write.
  assign wr_en     = cap_pulse & (~full | pop) & ~clr;
  assign pop_en    = pop & ~clr;

  // Pointer, occupancy and sticky overflow bookkeeping; clr discards the cycle's events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (pop_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (cap_pulse & full & ~pop) overflow <= 1'b1;
    end
  end

  // Storage is not reset; only entries below the read pointer's occupancy are ever shown.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= count_in;
  end

  assign cap_data = cap_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a queue-based model.
module tb_count_capture_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             trig_in = 1'b0;
  logic             clr = 1'b0;
  logic             rd_ack = 1'b0;
  logic [WIDTH-1:0] cap_data;
  logic             cap_valid;
  logic             overflow;
  logic [2:0]       level;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .trig_in(trig_in), .clr(clr),
    .rd_ack(rd_ack), .cap_data(cap_data), .cap_valid(cap_valid),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // Behavioural model: trigger samples taken at each edge, a queue for the FIFO.
  bit               hist[$];
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;

  always @(posedge clk or negedge rst_n) begin
    bit pulse, popped, was_full;
    if (!rst_n) begin
      hist = '{0, 0, 0};
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      // hist[0] = sample one edge ago, hist[1] = two ago, hist[2] = three ago
      pulse = hist[1] && !hist[2];
      hist.push_front(trig_in);
      while (hist.size() > 3) void'(hist.pop_back());
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        was_full = (mq.size() == DEPTH);
        popped   = rd_ack && (mq.size() != 0);
        if (popped) void'(mq.pop_front());
        if (pulse) begin
          if (!was_full || popped) mq.push_back(count_in);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] e_data;
    if (chk_en) begin
      e_data = (mq.size() != 0) ? mq[0] : '0;
      vectors++;
      if (cap_valid !== (mq.size() != 0) || level !== 3'(mq.size()) ||
          overflow !== m_ovf || cap_data !== e_data) begin
        miscompares++;
        $display("FAIL model t=%0t got v=%0b lvl=%0d ovf=%0b data=%02h, want v=%0b lvl=%0d ovf=%0b data=%02h",
                 $time, cap_valid, level, overflow, cap_data,
                 mq.size() != 0, mq.size(), m_ovf, e_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // One isolated trigger pulse; the capture edge is the third tick, with count_in=v.
  task automatic capture(input logic [WIDTH-1:0] v);
    count_in = v;
    trig_in = 1'b1; tick();
    trig_in = 1'b0; tick();
    tick();
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    // 1. reset
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; chk_en = 1'b1;
    chk("rst_valid", 32'(cap_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(cap_data), 0);

    // 2. first capture latency
    count_in = 8'h0e; trig_in = 1'b1; tick();
    count_in = 8'h0f; trig_in = 1'b0; tick();
    chk("lat_not_yet", 32'(cap_valid), 0);
    count_in = 8'h10; tick();
    count_in = 8'h11;
    chk("lat_valid", 32'(cap_valid), 1);
    chk("lat_data", 32'(cap_data), 32'h10);
    chk("lat_level", 32'(level), 1);
    tick(); tick();

    // 3. overflow and in-order readout
    do_clr();
    for (int i = 0; i < 5; i++) capture(8'(8'h20 + i));
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk("pop_data", 32'(cap_data), 32'h20 + i);
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    end
    chk("drain_valid", 32'(cap_valid), 0);
    chk("drain_ovf", 32'(overflow), 1);

    // 4. full with simultaneous write and pop
    do_clr();
    for (int i = 0; i < 4; i++) capture(8'(8'h30 + i));
    count_in = 8'h34;
    trig_in = 1'b1; tick();
    trig_in = 1'b0; tick();
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("fullrw_level", 32'(level), 4);
    chk("fullrw_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk("fullrw_data", 32'(cap_data), 32'h31 + i);
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    end

    // 5. held level gives one capture; reset mid-hold gives one more
    do_clr();
    count_in = 8'h40; trig_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_level", 32'(level), 1);
    chk("hold_data", 32'(cap_data), 32'h40);
    rst_n = 1'b0; tick();
    chk("hold_rst_level", 32'(level), 0);
    count_in = 8'h50; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_rel_level", 32'(level), 1);
    chk("hold_rel_data", 32'(cap_data), 32'h50);
    trig_in = 1'b0; tick(); tick(); tick();

    // 6. clr beats a same-cycle capture and clears overflow
    do_clr();
    for (int i = 0; i < 5; i++) capture(8'(8'h60 + i));
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("pre_clr_level", 32'(level), 3);
    chk("pre_clr_ovf", 32'(overflow), 1);
    count_in = 8'h65;
    trig_in = 1'b1; tick();
    trig_in = 1'b0; tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_level", 32'(level), 0);
    chk("clr_valid", 32'(cap_valid), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_data", 32'(cap_data), 0);
    tick(); tick();
    chk("clr_after_level", 32'(level), 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      count_in = 8'($urandom);
      trig_in  = ($urandom_range(0, 2) == 0);
      rd_ack   = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1; clr = 1'b0; rd_ack = 1'b0; trig_in = 1'b0;
    tick(); tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
